calc1_port_responder: RTL and testbench
=======================================

// Module: calc1_port_responder
// PURPOSE
//  Single-port responder for the calc1 request protocol: accepts cmd+operand1, then operand2, computes, returns one response.
//  Sits behind each of the four calc1 request ports as a golden reference and stand-in DUV.
//  Driven by calc1_driver-style stimulus; the checker compares DUV responses against it.
// PARAMETERS
//  RESP_LAT  3  cycles from operand2 sample edge to the response cycle, legal 1..15
//  DW        32 operand/result width, big-endian [0:DW-1]
// PORTS
//  c_clk          in   1   clock; all state updates on posedge
//  reset          in   1   synchronous, active-high
//  req_cmd_in     in   4   0 NOP, 1 ADD, 2 SUB, 5 LSH, 6 RSH, others invalid
//  req_data_in    in   DW  operand1 with cmd, operand2 on following cycle
//  out_resp       out  2   0 none, 1 success, 2 overflow/underflow/invalid cmd, 3 never driven
//  out_data       out  DW  result, valid only when out_resp==1, else 0
//  busy           out  1   high from operand1 capture through the response cycle
// BEHAVIOUR
//  Reset: out_resp=0, out_data=0, busy=0, state IDLE, latency counter 0, operand regs 0.
//  Reset wins over all other activity; asserting reset in any state aborts, no response emitted.
//  FSM: IDLE -> OPND2 -> WAIT -> RESP -> IDLE.
//   IDLE: req_cmd_in!=NOP at edge -> latch cmd, op1=req_data_in, busy=1, go OPND2.
//   OPND2: latch op2=req_data_in (req_cmd_in ignored), compute result+status, cnt=RESP_LAT-1;
//          RESP_LAT==1 -> RESP directly, else WAIT.
//   WAIT: cnt decrements each edge; at cnt==1 go RESP.
//   RESP: out_resp/out_data held exactly one cycle; next edge out_resp=0, out_data=0, busy=0, go IDLE.
//  Response appears RESP_LAT cycles after operand2 edge (RESP_LAT=3 -> 4 cycles after cmd edge).
//  Non-NOP cmd while busy: ignored, not queued (driver never overlaps on one port).
//  ADD: 33-bit sum; carry-out -> resp 2, data 0; else resp 1, data = low DW bits.
//  SUB: op2>op1 (unsigned) -> resp 2, data 0; else resp 1, data=op1-op2; equal -> resp 1, data 0.
//  LSH/RSH: logical, zero fill; amount = op2[DW-5:DW-1] (mod 32), upper op2 bits ignored; always resp 1.
//   shift 32 -> amount 0 -> data=op1; shift 0xFFFFFFFF -> amount 31.
//  Invalid cmd (3,4,7..15): consumes operand2 slot, resp 2, data 0.
// CONFIGURATION
//  CALC1_STATS_EN defined: extra outputs stat_ok[15:0], stat_err[15:0]; increment on each resp 1 / resp 2 cycle,
//   saturate at 0xFFFF, clear on reset. Ports and counters absent when undefined; core behaviour identical.
// STRUCTURE
//  calc1_pkg: CMD_NOP/ADD/SUB/LSH/RSH, RESP_NONE/OK/ERR localparams, FSM state encoding.
//  Sub-module calc1_alu: combinational cmd/op1/op2 -> result, status; instantiated once, registered in OPND2.
//  Top holds FSM, latency counter, operand/result registers, optional stats counters.
// TESTING
//  reset held 2 cycles mid-WAIT of ADD 1+1 -> no response ever; busy=0, out_resp=0 next edge after reset.
//  ADD 0xFFFF0000,0x0000FFFF -> resp 1, data 0xFFFFFFFF exactly RESP_LAT cycles after op2 edge, one cycle wide.
//  ADD 0xFFFFFFFF,0x00000001 -> resp 2, data 0; SUB 0x00000000,0x00000001 -> resp 2, data 0.
//  SUB 0xFFFF0000,0x0000FFFF -> resp 1, data 0xFFFE0001; SUB 0xFFFFFFFF,0xFFFFFFFF -> resp 1, data 0.
//  LSH 0x00000001,31 -> 0x80000000; RSH 0xF0F0F0F0,4 -> 0x0F0F0F0F; LSH 0xFFFFFFFF,32 -> 0xFFFFFFFF; all resp 1.
//  cmd 3 with operands 5,6 -> resp 2; ADD issued while busy ignored; with CALC1_STATS_EN stat_err increments by 1.

Source files
------------

// File: rtl/calc1_pkg.sv
// calc1 request protocol constants and the port responder FSM encoding.
package calc1_pkg;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_LSH = 4'd5;
    localparam logic [3:0] CMD_RSH = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPND2,
        S_WAIT,
        S_RESP
    } state_t;

endpackage

// File: rtl/calc1_port_responder_if.sv
// Request/response bundle of one calc1 port.
// CALC1_STATS_EN adds the stat_ok/stat_err counters.
interface calc1_port_responder_if #(
    parameter int DW = 32
);

    logic [3:0]    req_cmd_in;
    logic [0:DW-1] req_data_in;
    logic [1:0]    out_resp;
    logic [0:DW-1] out_data;
    logic          busy;
`ifdef CALC1_STATS_EN
    logic [15:0]   stat_ok;
    logic [15:0]   stat_err;

    modport master (
        output req_cmd_in, req_data_in,
        input  out_resp, out_data, busy, stat_ok, stat_err
    );
    modport slave (
        input  req_cmd_in, req_data_in,
        output out_resp, out_data, busy, stat_ok, stat_err
    );
`else
    modport master (
        output req_cmd_in, req_data_in,
        input  out_resp, out_data, busy
    );
    modport slave (
        input  req_cmd_in, req_data_in,
        output out_resp, out_data, busy
    );
`endif

endinterface

// File: rtl/calc1_alu.sv
// Combinational calc1 datapath: cmd/op1/op2 to result and response code.
// Error responses always carry zero data.
module calc1_alu
    import calc1_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [3:0]    cmd,
    input  logic [0:DW-1] op1,
    input  logic [0:DW-1] op2,
    output logic [0:DW-1] result,
    output logic [1:0]    status
);

    logic [DW:0] sum;
    logic [4:0]  amt;

    always_comb begin
        result = '0;
        status = RESP_ERR;
        sum    = {1'b0, op1} + {1'b0, op2};
        amt    = op2[DW-5:DW-1];
        unique case (1'b1)
            cmd == CMD_ADD: begin
                if (!sum[DW]) begin
                    status = RESP_OK;
                    result = sum[DW-1:0];
                end
            end
            cmd == CMD_SUB: begin
                if (op2 <= op1) begin
                    status = RESP_OK;
                    result = op1 - op2;
                end
            end
            cmd == CMD_LSH: begin
                status = RESP_OK;
                result = op1 << amt;
            end
            cmd == CMD_RSH: begin
                status = RESP_OK;
                result = op1 >> amt;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/calc1_port_responder.sv
// Single-port calc1 responder: cmd+op1, op2, RESP_LAT wait, one response.
// CALC1_STATS_EN enables saturating ok/err response counters.
module calc1_port_responder
    import calc1_pkg::*;
#(
    parameter int RESP_LAT = 3,
    parameter int DW       = 32
) (
    input logic c_clk,
    input logic reset,
    calc1_port_responder_if.slave bus
);

    localparam logic [3:0] LAT_M1 = 4'(RESP_LAT - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [0:DW-1] op1_q, op1_d;
    logic [0:DW-1] op2_q, op2_src;
    logic [0:DW-1] res_q, res_d;
    logic [1:0]    st_q, st_d;
    logic [1:0]    resp_q, resp_d;
    logic [0:DW-1] data_q, data_d;
    logic          busy_q, busy_d;
    logic [0:DW-1] alu_res;
    logic [1:0]    alu_st;

    // op2 feeds the ALU live in its sample cycle so the result registers with it
    assign op2_src = (state_q == S_OPND2) ? bus.req_data_in : op2_q;

    calc1_alu #(.DW(DW)) u_alu (
        .cmd    (cmd_q),
        .op1    (op1_q),
        .op2    (op2_src),
        .result (alu_res),
        .status (alu_st)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        op1_d   = op1_q;
        res_d   = res_q;
        st_d    = st_q;
        resp_d  = resp_q;
        data_d  = data_q;
        busy_d  = busy_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_cmd_in != CMD_NOP) begin
                    cmd_d   = bus.req_cmd_in;
                    op1_d   = bus.req_data_in;
                    busy_d  = 1'b1;
                    state_d = S_OPND2;
                end
            end
            S_OPND2: begin
                res_d = alu_res;
                st_d  = alu_st;
                cnt_d = LAT_M1;
                if (RESP_LAT == 1) begin
                    resp_d  = alu_st;
                    data_d  = alu_res;
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    resp_d  = st_q;
                    data_d  = res_q;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                resp_d  = RESP_NONE;
                data_d  = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            res_q   <= '0;
            st_q    <= RESP_NONE;
            resp_q  <= RESP_NONE;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_src;
            res_q   <= res_d;
            st_q    <= st_d;
            resp_q  <= resp_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.out_resp = resp_q;
    assign bus.out_data = data_q;
    assign bus.busy     = busy_q;

`ifdef CALC1_STATS_EN
    logic [15:0] ok_q;
    logic [15:0] err_q;

    // resp_d carries a response code only on the edge entering RESP
    always_ff @(posedge c_clk) begin
        if (reset) begin
            ok_q  <= '0;
            err_q <= '0;
        end else begin
            if (resp_d == RESP_OK && ok_q != 16'hFFFF)
                ok_q <= ok_q + 16'd1;
            if (resp_d == RESP_ERR && err_q != 16'hFFFF)
                err_q <= err_q + 16'd1;
        end
    end

    assign bus.stat_ok  = ok_q;
    assign bus.stat_err = err_q;
`endif

endmodule

// File: tb/tb_calc1_port_responder.sv
// Scoreboard bench for calc1_port_responder against an arithmetic reference.
// Build with CALC1_STATS_EN to also check the error counter.
module tb_calc1_port_responder;

    localparam int RESP_LAT = 3;

    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  resp;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic c_clk = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];

    calc1_port_responder_if #(.DW(32)) bus ();

    calc1_port_responder #(.RESP_LAT(RESP_LAT), .DW(32)) dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 c_clk = ~c_clk;
    always @(posedge c_clk) cyc <= cyc + 1;

    function automatic void model(input logic [3:0] c, input logic [31:0] a,
                                  input logic [31:0] b, output logic [1:0] r,
                                  output logic [31:0] d);
        longint unsigned s;
        r = 2'd2;
        d = 32'd0;
        case (c)
            4'd1: begin
                s = longint'(a) + longint'(b);
                if (s < 64'h1_0000_0000) begin
                    r = 2'd1;
                    d = 32'(s);
                end
            end
            4'd2: if (b <= a) begin r = 2'd1; d = a - b; end
            4'd5: begin r = 2'd1; d = a << (b % 32); end
            4'd6: begin r = 2'd1; d = a >> (b % 32); end
            default: ;
        endcase
    endfunction

    task automatic monitor();
        exp_t e;
        logic [31:0] od;
        forever begin
            @(negedge c_clk);
            if (reset) continue;
            od = bus.out_data;
            while (expq.size() > 0 && expq[0].due < cyc) begin
                e = expq.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_resp cmd=%0d due=%0d now=%0d", e.cmd, e.due, cyc);
            end
            checks++;
            if (bus.out_resp != 2'd0) begin
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp got resp=%0d data=%h at %0d, want none",
                             bus.out_resp, od, cyc);
                end else begin
                    e = expq.pop_front();
                    if (bus.out_resp != e.resp || od != e.data || cyc != e.due) begin
                        errors++;
                        $display("FAIL resp_cmd%0d got resp=%0d data=%h cyc=%0d, want resp=%0d data=%h cyc=%0d",
                                 e.cmd, bus.out_resp, od, cyc, e.resp, e.data, e.due);
                    end
                end
            end else if (od != 32'd0) begin
                errors++;
                $display("FAIL idle_data got %h want 00000000", od);
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy) begin
            @(negedge c_clk);
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL busy_timeout got busy=1 after %0d cycles want 0", n);
                break;
            end
        end
    endtask

    task automatic issue(input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input bit track);
        logic [1:0]  r;
        logic [31:0] d;
        wait_idle();
        @(negedge c_clk);
        bus.req_cmd_in  = c;
        bus.req_data_in = a;
        @(negedge c_clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_set got %b want 1", bus.busy);
        end
        bus.req_cmd_in  = 4'($urandom_range(0, 15));
        bus.req_data_in = b;
        if (track) begin
            model(c, a, b, r, d);
            expq.push_back('{c, r, d, cyc + RESP_LAT});
        end
        @(negedge c_clk);
        bus.req_cmd_in  = 4'd1;
        bus.req_data_in = $urandom;
        @(negedge c_clk);
        bus.req_cmd_in  = 4'd0;
    endtask

    logic [3:0]  dir_cmd [10] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd5, 4'd6, 4'd5, 4'd5, 4'd3};
    logic [31:0] dir_a   [10] = '{32'hFFFF0000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFF0000,
                                  32'hFFFFFFFF, 32'h00000001, 32'hF0F0F0F0, 32'hFFFFFFFF,
                                  32'h12345678, 32'd5};
    logic [31:0] dir_b   [10] = '{32'h0000FFFF, 32'h00000001, 32'h00000001, 32'h0000FFFF,
                                  32'hFFFFFFFF, 32'd31, 32'd4, 32'd32,
                                  32'hFFFFFFFF, 32'd6};
    logic [3:0]  cmd_tab [8]  = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd4, 4'd7, 4'd15};

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
`ifdef CALC1_STATS_EN
        logic [15:0] err0;
`endif
        bus.req_cmd_in  = 4'd0;
        bus.req_data_in = 32'd0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge c_clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.out_resp !== 2'd0 || bus.out_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_state got busy=%b resp=%0d data=%h want 0/0/0",
                     bus.busy, bus.out_resp, bus.out_data);
        end
        reset = 1'b0;

        for (int i = 0; i < 10; i++)
            issue(dir_cmd[i], dir_a[i], dir_b[i], 1'b1);

        wait_idle();
        @(negedge c_clk);
        bus.req_cmd_in  = 4'd1;
        bus.req_data_in = 32'd1;
        @(negedge c_clk);
        bus.req_cmd_in  = 4'd0;
        @(negedge c_clk);
        reset = 1'b1;
        @(negedge c_clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.out_resp !== 2'd0) begin
            errors++;
            $display("FAIL reset_abort got busy=%b resp=%0d want 0/0", bus.busy, bus.out_resp);
        end
        @(negedge c_clk);
        reset = 1'b0;
        @(negedge c_clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.out_resp !== 2'd0) begin
            errors++;
            $display("FAIL post_reset got busy=%b resp=%0d want 0/0", bus.busy, bus.out_resp);
        end
        repeat (8) @(negedge c_clk);

`ifdef CALC1_STATS_EN
        err0 = bus.stat_err;
        issue(4'd3, 32'd5, 32'd6, 1'b1);
        wait_idle();
        checks++;
        if (bus.stat_err != err0 + 16'd1) begin
            errors++;
            $display("FAIL stat_err got %0d want %0d", bus.stat_err, err0 + 16'd1);
        end
`endif

        for (int i = 0; i < 80; i++)
            issue(cmd_tab[$urandom_range(0, 7)], pick(), pick(), 1'b1);

        wait_idle();
        repeat (4) @(negedge c_clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
